// File: rtl/panel_ctrl_arbiter.sv
// Two-source burst arbiter feeding the six panel drivers' write port.
// Grants whole bursts round-robin and force-releases an owner that stalls too long.
module panel_ctrl_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  src_enable,
  input  logic        s0_valid,
  input  logic        s1_valid,
  output logic        s0_ready,
  output logic        s1_ready,
  input  logic        s0_last,
  input  logic        s1_last,
  input  logic [5:0]  s0_en,
  input  logic [5:0]  s1_en,
  input  logic [3:0]  s0_wr,
  input  logic [3:0]  s1_wr,
  input  logic [15:0] s0_addr,
  input  logic [15:0] s1_addr,
  input  logic [23:0] s0_wdat,
  input  logic [23:0] s1_wdat,
  output logic [5:0]  ctrl_en,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic        busy,
  output logic        owner,
  output logic [7:0]  timeout_cnt
);

  localparam int unsigned STALL_W = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic               rr_last;
  logic [STALL_W-1:0] stall_cnt;

  logic        elig0, elig1, grant_sel, in_burst, accept, stall_hit;
  logic        cur_valid, cur_last;
  logic [5:0]  cur_en;
  logic [3:0]  cur_wr;
  logic [15:0] cur_addr;
  logic [23:0] cur_wdat;

  // Owner's beat fields; the non-owner's inputs never reach the datapath
  assign cur_valid = owner ? s1_valid : s0_valid;
  assign cur_last  = owner ? s1_last  : s0_last;
  assign cur_en    = owner ? s1_en    : s0_en;
  assign cur_wr    = owner ? s1_wr    : s0_wr;
  assign cur_addr  = owner ? s1_addr  : s0_addr;
  assign cur_wdat  = owner ? s1_wdat  : s0_wdat;

  assign in_burst  = (state == BURST);
  assign s0_ready  = resetn && in_burst && !owner;
  assign s1_ready  = resetn && in_burst && owner;
  assign accept    = resetn && in_burst && cur_valid;
  assign stall_hit = (stall_cnt == STALL_W'(TIMEOUT - 1));
  assign busy      = in_burst;

  // On a tie the requester that did not hold the last burst wins
  assign elig0     = s0_valid && src_enable[0];
  assign elig1     = s1_valid && src_enable[1];
  assign grant_sel = (elig0 && elig1) ? !rr_last : elig1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      stall_cnt   <= '0;
      timeout_cnt <= '0;
      ctrl_en     <= '0;
      ctrl_wr     <= '0;
      ctrl_addr   <= '0;
      ctrl_wdat   <= '0;
    end else begin
      ctrl_en <= '0;
      if (accept) begin
        ctrl_en   <= cur_en;
        ctrl_wr   <= cur_wr;
        ctrl_addr <= cur_addr;
        ctrl_wdat <= cur_wdat;
      end

      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            state     <= BURST;
            owner     <= grant_sel;
            stall_cnt <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            stall_cnt <= '0;
            if (cur_last) begin
              state   <= IDLE;
              rr_last <= owner;
            end
          end else if (stall_hit) begin
            // Forced release of a stalled owner
            state     <= IDLE;
            rr_last   <= owner;
            stall_cnt <= '0;
            if (timeout_cnt != {CNT_W{1'b1}}) timeout_cnt <= timeout_cnt + CNT_W'(1);
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
